// File: rtl/tree_vote_scheduler.sv
// Shares one tree-evaluation port across all class trees, counts one vote
// counter per class, then reports the argmax class with a valid/ready result.
module tree_vote_scheduler #(
    parameter int NUM_FEAT        = 51,
    parameter int NUM_CLASSES     = 5,
    parameter int TREES_PER_CLASS = 6
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_in_valid,
    output logic                            o_in_ready,
    input  logic [NUM_FEAT-1:0]             i_in_features,
    output logic [NUM_FEAT-1:0]             o_tree_feat,
    output logic [$clog2(NUM_CLASSES)-1:0]  o_tree_class,
    output logic [((TREES_PER_CLASS > 1) ? $clog2(TREES_PER_CLASS) : 1)-1:0] o_tree_idx,
    output logic                            o_tree_en,
    input  logic                            i_tree_out,
    output logic                            o_out_valid,
    input  logic                            i_out_ready,
    output logic [$clog2(NUM_CLASSES)-1:0]  o_out_class,
    output logic [$clog2(TREES_PER_CLASS+1)-1:0] o_out_votes,
    output logic                            o_out_tie
);
    localparam int CW = $clog2(NUM_CLASSES);
    localparam int TW = (TREES_PER_CLASS > 1) ? $clog2(TREES_PER_CLASS) : 1;
    localparam int VW = $clog2(TREES_PER_CLASS + 1);
    localparam logic [CW-1:0] LAST_C = CW'(NUM_CLASSES - 1);
    localparam logic [TW-1:0] LAST_T = TW'(TREES_PER_CLASS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EVAL   = 2'd1,
        S_DECIDE = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    state_t             r_state;
    logic [NUM_FEAT-1:0] r_feat;
    logic [CW-1:0]      r_cls;
    logic [TW-1:0]      r_idx;
    logic               r_tree_en;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [CW-1:0]      r_out_class;
    logic [VW-1:0]      r_out_votes;
    logic               r_out_tie;
    logic [VW-1:0]      r_votes [NUM_CLASSES];

    logic [CW-1:0]      w_best_cls;
    logic [VW-1:0]      w_best_votes;
    logic               w_tie;

    // Strict '>' keeps the lowest class index on equal counts
    always_comb begin
        w_best_cls   = '0;
        w_best_votes = r_votes[0];
        w_tie        = 1'b0;
        for (int k = 1; k < NUM_CLASSES; k++) begin
            if (r_votes[k] > w_best_votes) begin
                w_best_votes = r_votes[k];
                w_best_cls   = CW'(k);
            end
        end
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (CW'(k) != w_best_cls && r_votes[k] == w_best_votes)
                w_tie = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_feat      <= '0;
            r_cls       <= '0;
            r_idx       <= '0;
            r_tree_en   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_class <= '0;
            r_out_votes <= '0;
            r_out_tie   <= 1'b0;
            for (int k = 0; k < NUM_CLASSES; k++)
                r_votes[k] <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_feat     <= i_in_features;
                        r_cls      <= '0;
                        r_idx      <= '0;
                        r_tree_en  <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= S_EVAL;
                        for (int k = 0; k < NUM_CLASSES; k++)
                            r_votes[k] <= '0;
                    end
                end
                S_EVAL: begin
                    if (i_tree_out)
                        r_votes[r_cls] <= r_votes[r_cls] + 1'b1;
                    if (r_idx == LAST_T) begin
                        r_idx <= '0;
                        if (r_cls == LAST_C) begin
                            r_cls     <= '0;
                            r_tree_en <= 1'b0;
                            r_state   <= S_DECIDE;
                        end else begin
                            r_cls <= r_cls + 1'b1;
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DECIDE: begin
                    r_out_class <= w_best_cls;
                    r_out_votes <= w_best_votes;
                    r_out_tie   <= w_tie;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_tree_feat  = r_feat;
    assign o_tree_class = r_cls;
    assign o_tree_idx   = r_idx;
    assign o_tree_en    = r_tree_en;
    assign o_out_valid  = r_out_valid;
    assign o_out_class  = r_out_class;
    assign o_out_votes  = r_out_votes;
    assign o_out_tie    = r_out_tie;
endmodule

// File: tb/tb_tree_vote_scheduler.sv
// Directed bench for tree_vote_scheduler: the tree bank is a 30-bit vote
// pattern indexed by class*6+idx, expected results are hand-computed.
module tb_tree_vote_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [50:0] in_features;
    logic [50:0] tree_feat;
    logic [2:0]  tree_class;
    logic [2:0]  tree_idx;
    logic        tree_en;
    logic        tree_out;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_class;
    logic [2:0]  out_votes;
    logic        out_tie;

    logic [29:0] pat;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    tree_vote_scheduler dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_in_features (in_features),
        .o_tree_feat   (tree_feat),
        .o_tree_class  (tree_class),
        .o_tree_idx    (tree_idx),
        .o_tree_en     (tree_en),
        .i_tree_out    (tree_out),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_class   (out_class),
        .o_out_votes   (out_votes),
        .o_out_tie     (out_tie)
    );

    // Drives 1 while disabled so an ignored tree_out would corrupt counts
    always_comb begin
        tree_out = 1'b1;
        if (tree_en && tree_class < 3'd5 && tree_idx < 3'd6)
            tree_out = pat[int'(tree_class) * 6 + int'(tree_idx)];
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic accept(input logic [50:0] f);
        @(negedge clk);
        chk("accept_ready", 64'(in_ready), 64'd1);
        in_valid    = 1'b1;
        in_features = f;
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
        in_features = '0;
    endtask

    // Called at the negedge right after the accept edge
    task automatic run_vec(input string tag, input logic [50:0] f,
                           input int e_cls, input int e_votes, input int e_tie);
        int cyc;
        int en_cnt;
        int walk_ok;
        int feat_ok;
        cyc = 0; en_cnt = 0; walk_ok = 1; feat_ok = 1;
        while (!out_valid && cyc < 100) begin
            if (tree_en) begin
                if (int'(tree_class) != en_cnt / 6 || int'(tree_idx) != en_cnt % 6)
                    walk_ok = 0;
                en_cnt++;
            end
            if (tree_feat !== f) feat_ok = 0;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd31);
        chk({tag, "_en_cycles"}, 64'(en_cnt), 64'd30);
        chk({tag, "_walk"}, 64'(walk_ok), 64'd1);
        chk({tag, "_feat"}, 64'(feat_ok), 64'd1);
        chk({tag, "_class"}, 64'(out_class), 64'(e_cls));
        chk({tag, "_votes"}, 64'(out_votes), 64'(e_votes));
        chk({tag, "_tie"}, 64'(out_tie), 64'(e_tie));
        chk({tag, "_busy"}, 64'(in_ready), 64'd0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_hs_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_hs_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_hs_en"}, 64'(tree_en), 64'd0);
    endtask

    initial begin
        int stable;
        int seen;
        logic [2:0] c0, v0;
        logic       t0;
        rst = 1'b1; in_valid = 1'b0; in_features = '0;
        out_ready = 1'b0; pat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_tree_en", 64'(tree_en), 64'd0);
        chk("rst_class_idx", 64'({tree_class, tree_idx}), 64'd0);
        chk("rst_feat", 64'(tree_feat), 64'd0);
        chk("rst_outs", 64'({out_class, out_votes, out_tie}), 64'd0);

        // Reset mid-EVAL aborts, nothing emitted afterwards
        pat = {6'h3f, 24'h0};
        accept(51'h5_5555_AAAA_1234);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_tree_en", 64'(tree_en), 64'd0);
        chk("abort_feat", 64'(tree_feat), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid || tree_en || !in_ready) seen = 1;
        end
        chk("abort_quiet", 64'(seen), 64'd0);

        // Only class 3 votes
        pat = {6'h00, 6'h3f, 6'h00, 6'h00, 6'h00};
        accept(51'h1_2345_6789_ABCD);
        run_vec("cls3", 51'h1_2345_6789_ABCD, 3, 6, 0);
        handshake("cls3");

        // Back-to-back: all trees vote, five-way tie at 6
        pat = '1;
        accept(51'h7_FFFF_FFFF_FFFF);
        run_vec("allone", 51'h7_FFFF_FFFF_FFFF, 0, 6, 1);
        handshake("allone");

        // Class 1 and 4 tie at 4, others 2
        pat = {6'h0f, 6'h03, 6'h03, 6'h0f, 6'h03};
        accept(51'h0_0F0F_1234_5678);
        run_vec("tie", 51'h0_0F0F_1234_5678, 1, 4, 1);
        handshake("tie");

        pat = '0;
        accept(51'h2_0000_0000_0001);
        run_vec("zero", 51'h2_0000_0000_0001, 0, 0, 1);
        handshake("zero");

        // Backpressure with a competing input offered
        pat = {6'h01, 6'h07, 6'h1f, 6'h03, 6'h00};
        accept(51'h3_3333_3333_3333);
        run_vec("bp", 51'h3_3333_3333_3333, 2, 5, 0);
        c0 = out_class; v0 = out_votes; t0 = out_tie;
        in_valid = 1'b1;
        in_features = 51'h6_6666_6666_6666;
        stable = 1;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || in_ready || tree_en || out_class !== c0 ||
                out_votes !== v0 || out_tie !== t0 ||
                tree_feat !== 51'h3_3333_3333_3333)
                stable = 0;
        end
        in_valid = 1'b0;
        chk("bp_stable", 64'(stable), 64'd1);
        handshake("bp");
        @(negedge clk);
        chk("bp_idle_hold", 64'({in_ready, out_valid, tree_en}), 64'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
